// File: rtl/norm_shift_decoder.sv
// norm_shift_decoder: serial post-add normalizer.
// Shifts the sum mantissa until its leading one sits on the hidden-bit position
// (MW-2), adjusting the exponent, and flags zero / underflow / overflow results.
module norm_shift_decoder #(
   parameter int unsigned MW = 12,
   parameter int unsigned EW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [MW-1:0] mant_in,
   input  logic [EW-1:0] exp_in,
   input  logic [3:0]    lead_idx,
   input  logic          idx_valid,
   output logic [MW-1:0] mant_out,
   output logic [EW-1:0] exp_out,
   output logic          busy,
   output logic          done,
   output logic          zero,
   output logic          underflow,
   output logic          overflow
);

   localparam int unsigned CW = 4;
   localparam logic [EW-1:0] EMAX     = '1;
   localparam logic [EW-1:0] EMAX_M1  = EW'((2**EW) - 2);
   localparam logic [EW-1:0] EXP_ONE  = EW'(1);
   localparam logic [CW-1:0] IDX_TOP  = CW'(MW - 1);
   localparam logic [CW-1:0] IDX_HID  = CW'(MW - 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [MW-1:0]   mant_q, mant_d;
   logic [EW-1:0]   exp_q, exp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dir_right_q, dir_right_d;
   logic            zero_q, zero_d;
   logic            underflow_q, underflow_d;
   logic            overflow_q, overflow_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   // State and datapath registers, all cleared by async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mant_q      <= '0;
         exp_q       <= '0;
         cnt_q       <= '0;
         dir_right_q <= 1'b0;
         zero_q      <= 1'b0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mant_q      <= mant_d;
         exp_q       <= exp_d;
         cnt_q       <= cnt_d;
         dir_right_q <= dir_right_d;
         zero_q      <= zero_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and datapath: capture on start, then one shift action per cycle.
   always_comb begin
      state_d     = state_q;
      mant_d      = mant_q;
      exp_d       = exp_q;
      cnt_d       = cnt_q;
      dir_right_d = dir_right_q;
      zero_d      = zero_q;
      underflow_d = underflow_q;
      overflow_d  = overflow_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_SHIFT;
               mant_d      = mant_in;
               exp_d       = exp_in;
               cnt_d       = '0;
               dir_right_d = 1'b0;
               zero_d      = 1'b0;
               underflow_d = 1'b0;
               overflow_d  = 1'b0;
               if (!idx_valid || (lead_idx > IDX_TOP)) begin
                  // Encoder found no leading one: exact zero result.
                  mant_d = '0;
                  exp_d  = '0;
                  zero_d = 1'b1;
               end else if (exp_in == EMAX) begin
                  // Already inf/overflow: pass through untouched.
                  overflow_d = 1'b1;
               end else if (lead_idx == IDX_TOP) begin
                  dir_right_d = 1'b1;
                  cnt_d       = CW'(1);
               end else if (lead_idx < IDX_HID) begin
                  cnt_d = CW'(IDX_HID - lead_idx);
               end
            end
         end

         ST_SHIFT: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else if (dir_right_q) begin
               if (exp_q == EMAX_M1) begin
                  exp_d      = EMAX;
                  mant_d     = '0;
                  overflow_d = 1'b1;
               end else begin
                  mant_d = mant_q >> 1;
                  exp_d  = exp_q + EXP_ONE;
               end
               cnt_d = '0;
            end else if (exp_q <= EXP_ONE) begin
               // Exponent exhausted: leave a denormal mantissa as it stands.
               exp_d       = '0;
               underflow_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               mant_d = mant_q << 1;
               exp_d  = exp_q - EXP_ONE;
               cnt_d  = cnt_q - CW'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs registered from the next state so they align with the state.
   always_comb begin
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   assign mant_out  = mant_q;
   assign exp_out   = exp_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign zero      = zero_q;
   assign underflow = underflow_q;
   assign overflow  = overflow_q;

endmodule
